// File: rtl/uart_tx_sched_if.sv
// Request bus between byte requesters and the UART transmit scheduler.
//   req_valid  per-requester byte valid
//   req_data   requester i byte in bits [i*DATA_W +: DATA_W]
//   req_ready  accept strobe, one-hot or zero; a byte moves when valid & ready
//   grant_id   index of the requester owning the current/last frame
// master: requester side, slave: scheduler side.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [GW-1:0]             grant_id;

    modport master (output req_valid, req_data, input  req_ready, grant_id);
    modport slave  (input  req_valid, req_data, output req_ready, grant_id);
endinterface

// File: rtl/uart_tx_sched.sv
// Shares one UART transmit line between NUM_REQ byte requesters.
// Requests are arbitrated round-robin in IDLE; the granted byte is then sent
// as start / DATA_W data bits (LSB first) / STOP_BITS stop bits, each bit
// advanced by a rising edge of the baud square wave. A UBRR change reported by
// the baud generator drops the frame in flight and pulses abort.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   baud          baud square wave from the baud generator
//   ubrr_changed  high while the generator's divisor copy is stale
//   req_if        request bus (slave side): valid/data in, ready/grant_id out
//   tx            serial line, idle high, registered
//   busy          high whenever the FSM is not IDLE
//   abort         one-cycle pulse when a frame is dropped
module uart_tx_sched #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               baud,
    input  logic               ubrr_changed,
    uart_tx_sched_if.slave     req_if,
    output logic               tx,
    output logic               busy,
    output logic               abort
);
    localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_e;

    state_e            state_q, state_d;
    logic              baud_q, baud_d;
    logic              tx_q, tx_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic [GW-1:0]     grant_id_q, grant_id_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;

    logic              tick;
    logic              found;
    logic [GW-1:0]     g_idx;
    logic [NUM_REQ-1:0] ready;

    assign tick = baud & ~baud_q;

    // Round-robin search starting one past the last grant, wrapping.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        found = 1'b0;
        g_idx = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found && req_if.req_valid[(int'(last_grant_q) + off) % NUM_REQ]) begin
                found = 1'b1;
                g_idx = GW'((int'(last_grant_q) + off) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        baud_d       = baud;
        tx_d         = tx_q;
        abort_d      = 1'b0;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        ready        = '0;

        if (state_q == IDLE) begin
            tx_d = 1'b1;
            // A tick in the capture cycle is deliberately ignored: SYNC waits
            // for the next one so the start bit is a full baud period.
            if (found && !ubrr_changed) begin
                ready[g_idx] = 1'b1;
                shift_d      = req_if.req_data[int'(g_idx)*DATA_W +: DATA_W];
                grant_id_d   = g_idx;
                last_grant_d = g_idx;
                state_d      = SYNC;
            end
        end else if (ubrr_changed) begin
            // Abort takes priority over any tick in the same cycle.
            tx_d    = 1'b1;
            abort_d = 1'b1;
            state_d = IDLE;
        end else if (tick) begin
            unique case (state_q)
                SYNC: begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
                START: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q == BCW'(DATA_W - 1)) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) state_d = IDLE;
                    else                                 stop_cnt_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            baud_q       <= 1'b0;
            tx_q         <= 1'b1;
            abort_q      <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            grant_id_q   <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            tx_q         <= tx_d;
            abort_q      <= abort_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req_if.req_ready = ready;
    assign req_if.grant_id  = grant_id_q;
    assign tx               = tx_q;
    assign abort            = abort_q;
    assign busy             = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a UART receiver model decodes frames
// on tx and compares them against a queue of expected {byte, grant} entries
// pushed when requests are driven. A second instance with STOP_BITS=2 covers
// the double stop bit. Baud period is 8 clocks.
module tb_uart_tx_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud = 1'b0;
    logic baud_en = 1'b1;
    logic ubrr_changed = 1'b0;
    logic tx, busy, abort;
    logic tx2, busy2, abort2;

    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(2), .DATA_W(8)) if1 ();
    uart_tx_sched_if #(.NUM_REQ(2), .DATA_W(8)) if2 ();

    uart_tx_sched #(.NUM_REQ(2), .DATA_W(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .baud(baud), .ubrr_changed(ubrr_changed),
        .req_if(if1.slave), .tx(tx), .busy(busy), .abort(abort));

    uart_tx_sched #(.NUM_REQ(2), .DATA_W(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baud(baud), .ubrr_changed(ubrr_changed),
        .req_if(if2.slave), .tx(tx2), .busy(busy2), .abort(abort2));

    typedef struct {
        logic [7:0] data;
        logic [0:0] gid;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic [0:0] model_last = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [0:0] rr(input logic [1:0] mask, input logic [0:0] last);
        for (int off = 1; off <= 2; off++) begin
            if (mask[(int'(last) + off) % 2]) return 1'((int'(last) + off) % 2);
        end
        return last;
    endfunction

    // Free-running baud square wave, 8 clocks per period, gated by baud_en.
    initial begin
        logic [2:0] bcnt = '0;
        forever begin
            @(negedge clk);
            bcnt = bcnt + 3'd1;
            baud = baud_en & bcnt[2];
        end
    end

    // Receiver model for the STOP_BITS=1 instance: samples mid-bit.
    initial begin
        logic       prev = 1'b1;
        logic [7:0] b;
        logic [0:0] gid;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !tx) begin
                gid = if1.grant_id;
                repeat (4) @(negedge clk);
                check("start_bit", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    b[i] = tx;
                end
                repeat (8) @(negedge clk);
                check("stop_bit", 32'(tx), 32'd1);
                if (sb_q.size() == 0) begin
                    check("unexpected_frame", 32'(b), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("frame_data", 32'(b), 32'(e.data));
                    check("frame_grant", 32'(gid), 32'(e.gid));
                end
            end
            prev = tx;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    // Holds mask valid until n handshakes were seen, checking each grant.
    task automatic send(input logic [1:0] mask, input logic [7:0] d0, input logic [7:0] d1,
                        input int n, input bit push);
        logic [0:0] g;
        exp_t       e;
        int         t;
        if1.req_data  = {d1, d0};
        if1.req_valid = mask;
        for (int k = 0; k < n; k++) begin
            g = rr(mask, model_last);
            model_last = g;
            if (push) begin
                e.data = g ? d1 : d0;
                e.gid  = g;
                sb_q.push_back(e);
            end
            #1;
            t = 0;
            while (if1.req_ready == 2'b00 && t < 400) begin
                @(negedge clk);
                #1;
                t++;
            end
            check("grant_ready", 32'(if1.req_ready), 32'(2'b01 << g));
            @(negedge clk);
        end
        if1.req_valid = 2'b00;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb_q.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(sb_q.size() == 0 && !busy), 32'd1);
    endtask

    task automatic wait_start(output bit ok);
        int t = 0;
        while (tx && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = !tx;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         bad;
        logic [7:0] b;
        if1.req_valid = 2'b00;
        if1.req_data  = '0;
        if2.req_valid = 2'b00;
        if2.req_data  = '0;

        // Reset state
        do_reset();
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_grant", 32'(if1.grant_id), 32'd0);
        check("rst_ready", 32'(if1.req_ready), 32'd0);
        @(negedge clk);
        mon_en = 1'b1;

        // 1: single byte from requester 0; ready drops right after capture
        send(2'b01, 8'hA5, 8'h00, 1, 1'b1);
        #1;
        check("ready_one_cycle", 32'(if1.req_ready), 32'd0);
        drain();
        check("idle_tx", 32'(tx), 32'd1);

        // 2: fresh arbiter, both requesters held -> alternating grants
        do_reset();
        send(2'b11, 8'h11, 8'h22, 4, 1'b1);
        drain();

        // 3: abort while bit_cnt=3 in DATA
        mon_en = 1'b0;
        send(2'b11, 8'h3C, 8'hC3, 1, 1'b0);
        wait_start(ok);
        check("abort_start_seen", 32'(ok), 32'd1);
        repeat (4 + 8 * 4) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'd1);
        ubrr_changed = 1'b1;
        @(negedge clk);
        ubrr_changed = 1'b0;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_pulse", 32'(abort), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("abort_one_cycle", 32'(abort), 32'd0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        check("abort_no_retry", 32'(bad), 32'd0);
        // ubrr_changed high in IDLE blocks arbitration
        ubrr_changed  = 1'b1;
        if1.req_valid = 2'b11;
        bad = 0;
        repeat (4) begin
            #1;
            if (if1.req_ready !== 2'b00 || abort !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("ubrr_idle_block", 32'(bad), 32'd0);
        ubrr_changed  = 1'b0;
        if1.req_valid = 2'b00;
        @(negedge clk);
        mon_en = 1'b1;
        send(2'b11, 8'h3C, 8'hC3, 1, 1'b1);
        drain();

        // 4: reset mid-DATA, then requester 0 wins a tie
        mon_en = 1'b0;
        send(2'b11, 8'h5A, 8'h96, 1, 1'b0);
        wait_start(ok);
        check("rst_start_seen", 32'(ok), 32'd1);
        repeat (4 + 8 * 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_abort", 32'(abort), 32'd0);
        check("midrst_grant", 32'(if1.grant_id), 32'd0);
        rst = 1'b0;
        model_last = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        send(2'b11, 8'h5A, 8'h96, 1, 1'b1);
        drain();

        // 5: baud stalled after capture
        baud_en = 1'b0;
        @(negedge clk);
        send(2'b01, 8'hC3, 8'h00, 1, 1'b1);
        if1.req_valid = 2'b10;
        bad = 0;
        repeat (1000) begin
            #1;
            if (busy !== 1'b1 || tx !== 1'b1 || if1.req_ready !== 2'b00) bad++;
            @(negedge clk);
        end
        check("stall_hold", 32'(bad), 32'd0);
        if1.req_valid = 2'b00;
        baud_en = 1'b1;
        drain();

        // 6: STOP_BITS=2 instance, byte 0x00
        if2.req_data  = 16'h0000;
        if2.req_valid = 2'b01;
        bad = 0;
        #1;
        while (if2.req_ready == 2'b00 && bad < 400) begin
            @(negedge clk);
            #1;
            bad++;
        end
        check("sb2_ready", 32'(if2.req_ready), 32'd1);
        @(negedge clk);
        if2.req_valid = 2'b00;
        bad = 0;
        while (tx2 && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        repeat (4) @(negedge clk);
        check("sb2_start", 32'(tx2), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(negedge clk);
            b[i] = tx2;
        end
        check("sb2_data", 32'(b), 32'h00);
        repeat (8) @(negedge clk);
        check("sb2_stop1", 32'(tx2), 32'd1);
        repeat (8) @(negedge clk);
        check("sb2_stop2", 32'(tx2), 32'd1);
        check("sb2_busy_stop2", 32'(busy2), 32'd1);
        repeat (8) @(negedge clk);
        check("sb2_idle", 32'(busy2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
